mmio_uart_tx: RTL and testbench

Memory-mapped serial output port on the data side of the single-cycle MIPS core, downstream of the CPU's store path. It decodes CPU loads and stores addressed to its two-word window, queues the stored bytes in a FIFO, and serializes them as 8N1 UART frames on `tx`. The data-memory chip-select and read/write strobes are split so that accesses in the window reach this block instead of `dram`.

---
 rtl/mmio_uart_tx.sv | 211 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter on the CPU data side.
// A two-word window holds DATA (push a byte / read the FIFO count) and
// STATUS (read the flags / clear the sticky overflow). Stored bytes are
// queued in a circular FIFO and shifted out on tx, LSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high; pops the FIFO head as soon as one is present
// S_START | start bit (low) held for CLKS_PER_BIT cycles
// S_DATA  | shift[0] driven for CLKS_PER_BIT cycles per bit, 8 bits
// S_STOP  | stop bit (high) held for CLKS_PER_BIT cycles
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          w_tx_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          w_data_hit;
    logic          w_stat_hit;
    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_baud_done;
    logic          w_unused;

    assign w_data_hit  = (addr == BASE_ADDR);
    assign w_stat_hit  = (addr == (BASE_ADDR + 32'd4));
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_req  = cs && we && w_data_hit;
    // A full FIFO still takes the byte when the transmitter frees a slot on the same edge.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_set   = w_push_req && w_full && !w_pop;
    assign w_ovf_clr   = cs && we && w_stat_hit && wdata[3];
    assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));

    assign busy = (r_state != S_IDLE) || !w_empty;
    assign tx   = r_tx;

    // Only the low byte and the overflow-clear bit of the store data matter.
    assign w_unused = ^{wdata[31:8], wdata[6:4], wdata[2:0]};

    // Load data mux; zero outside the window or when no load is requested.
    always_comb begin
        rdata = 32'd0;
        if (cs && re) begin
            if (w_data_hit) begin
                rdata = 32'(r_count);
            end else if (w_stat_hit) begin
                rdata = {28'd0, r_ovf, busy, w_full, w_empty};
            end
        end
    end

    // Transmitter next-state, baud/bit counters, shifter and pop request.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_nxt   = '0;
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, so tx is a clean flop output.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // Transmitter registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx with CLKS_PER_BIT=4,
// FIFO_DEPTH=4. A transaction-level model (byte queue plus a "transmitter
// busy for N more cycles" counter) predicts accepted bytes and frame start
// times; a separate line monitor decodes tx and checks against the queue.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_q[$];
    int         m_remain = 0;
    bit         m_ovf    = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .re   (re),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit m_busy();
        return (m_remain > 0) || (m_q.size() > 0);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (a == BASE) return 32'(m_q.size());
        if (a == BASE + 32'd4)
            return {28'd0, m_ovf, m_busy(), m_q.size() == DEPTH, m_q.size() == 0};
        return 32'd0;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        exp_q.delete();
        m_remain = 0;
        m_ovf    = 1'b0;
    endfunction

    // Advance the model across the next rising edge.
    function automatic void model_edge(input bit push, input bit clr, input logic [7:0] b);
        bit   pop;
        bit   full;
        exp_t e;
        pop  = (m_remain == 0) && (m_q.size() > 0);
        full = (m_q.size() == DEPTH);
        if (pop) begin
            e.b = m_q.pop_front();
            e.c = cyc + 1;
            exp_q.push_back(e);
            m_remain = FRAME;
        end else if (m_remain > 0) begin
            m_remain--;
        end
        if (push && (!full || pop)) m_q.push_back(b);
        if (clr) m_ovf = 1'b0;
        if (push && full && !pop) m_ovf = 1'b1;
    endfunction

    // One bus cycle: drive after the falling edge, check, then model the edge.
    task automatic cyc_op(input bit c, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = c; we = w; re = r; addr = a; wdata = d;
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_busy()});
        if (c && r) check("rdata", rdata, m_rdata(a));
        model_edge(c && w && (a == BASE), c && w && (a == BASE + 32'd4) && d[3], d[7:0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_q.size() == 0 && m_remain == 0) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        check("drain_within_budget", {31'd0, ok}, 32'd1);
        idle(2);
    endtask

    // Line monitor: every frame sample is compared cycle by cycle.
    initial begin
        bit         in_frame;
        bit         skip;
        bit         bad;
        int         pos;
        int         bad_pos;
        logic [9:0] fr;
        exp_t       e;
        in_frame = 1'b0;
        skip     = 1'b0;
        bad      = 1'b0;
        pos      = 0;
        bad_pos  = 0;
        fr       = 10'h3ff;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    bad      = 1'b0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        skip = 1'b1;
                        $display("FAIL unexpected_frame: start bit at cycle %0d, none expected", cyc);
                    end else begin
                        skip = 1'b0;
                        e    = exp_q.pop_front();
                        fr   = {1'b1, e.b, 1'b0};
                        if (cyc != e.c) begin
                            n_bad++;
                            $display("FAIL frame_start: byte %h started cycle %0d want %0d", e.b, cyc, e.c);
                        end
                    end
                end
                if (in_frame) begin
                    if (!skip && !bad && tx !== fr[pos / CPB]) begin
                        bad     = 1'b1;
                        bad_pos = pos;
                    end
                    pos++;
                    if (pos == FRAME) begin
                        in_frame = 1'b0;
                        if (!skip) begin
                            n_cmp++;
                            if (bad) begin
                                n_bad++;
                                $display("FAIL frame_bits: byte %h wrong at cycle offset %0d, got tx=%b want %b",
                                         e.b, bad_pos, ~fr[bad_pos / CPB], fr[bad_pos / CPB]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Reset values through the STATUS register.
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("reset_status", rdata, 32'h1);

        // Single byte.
        cyc_op(1'b1, 1'b1, 1'b0, BASE, 32'hABCD_EF55);
        wait_drain();

        // Fill and overflow: 0x01..0x06 back to back.
        for (int i = 1; i <= 6; i++) cyc_op(1'b1, 1'b1, 1'b0, BASE, 32'(i));
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("ovf_set", {31'd0, rdata[3]}, 32'd1);
        cyc_op(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'd8);
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("ovf_cleared", {31'd0, rdata[3]}, 32'd0);
        wait_drain();

        // Push into a full FIFO on the edge that pops it.
        for (int i = 0; i < 5; i++) cyc_op(1'b1, 1'b1, 1'b0, BASE, 32'h40 + 32'(i));
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_remain == 0 && m_q.size() == DEPTH) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("full_pop_edge_reached", {31'd0, found}, 32'd1);
        cyc_op(1'b1, 1'b1, 1'b0, BASE, 32'h5A);
        cyc_op(1'b1, 1'b0, 1'b1, BASE, 32'd0);
        check("count_full_pop", rdata, 32'h4);
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("ovf_full_pop", {31'd0, rdata[3]}, 32'd0);
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] d;
            op = int'($urandom_range(0, 9));
            d  = $urandom();
            case (op)
                4, 5: cyc_op(1'b1, 1'b1, 1'b0, BASE, d);
                6:    cyc_op(1'b1, 1'b1, 1'b0, BASE + 32'd4, d);
                7:    cyc_op(1'b1, 1'b0, 1'b1, BASE, d);
                8:    cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, d);
                9:    cyc_op(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             (d[0] ? BASE + 32'd8 : $urandom()), d);
                default: idle(1);
            endcase
        end
        wait_drain();
        cyc_op(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'd8);

        // Reads: three queued, outside window, store outside window.
        for (int i = 0; i < 4; i++) cyc_op(1'b1, 1'b1, 1'b0, BASE, 32'hC0 + 32'(i));
        cyc_op(1'b1, 1'b0, 1'b1, BASE, 32'd0);
        check("count_three", rdata, 32'h3);
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd8, 32'd0);
        check("outside_read", rdata, 32'h0);
        cyc_op(1'b1, 1'b1, 1'b0, BASE + 32'd8, 32'hFF);
        cyc_op(1'b1, 1'b0, 1'b1, BASE, 32'd0);
        check("outside_store_no_push", rdata, 32'h3);
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("outside_store_no_ovf", {31'd0, rdata[3]}, 32'd0);

        // Async reset in the middle of data bit 3.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_remain == 22) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("mid_frame_reached", {31'd0, found}, 32'd1);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; re = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(60);
        cyc_op(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'd0);
        check("post_reset_status", rdata, 32'h1);
        idle(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
